// File: rtl/leds_arbiter_if.sv
// leds_arbiter_if: bundles the request/value/grant signals of the LED arbiter.
//   req   [3:0]      per-requester write request (bit i = requester i)
//   val0..val3 [15:0] LED value offered by each requester
//   ack   [3:0]      one-cycle one-hot grant acknowledge
//   leds  [15:0]     registered LED drive value
//   owner [1:0]      index of the requester that last wrote leds
//   busy             high while the arbiter holds the current value
// master: requester side (drives req/val*). slave: the arbiter.
interface leds_arbiter_if;
    logic [3:0]  req;
    logic [15:0] val0;
    logic [15:0] val1;
    logic [15:0] val2;
    logic [15:0] val3;
    logic [3:0]  ack;
    logic [15:0] leds;
    logic [1:0]  owner;
    logic        busy;

    modport master (
        output req, val0, val1, val2, val3,
        input  ack, leds, owner, busy
    );

    modport slave (
        input  req, val0, val1, val2, val3,
        output ack, leds, owner, busy
    );
endinterface

// File: rtl/leds_arbiter.sv
// leds_arbiter: round-robin arbiter for four writers sharing one 16-bit LED bank.
// A granted value is held for HOLD_CYCLES cycles (1..65535) before the next grant.
//   clock  rising-edge clock
//   reset  asynchronous, active-low reset
//   bus    leds_arbiter_if.slave: req/val0..3 in; ack/leds/owner/busy out (all registered)
module leds_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input logic           clock,
    input logic           reset,
    leds_arbiter_if.slave bus
);

    typedef enum logic [0:0] {StIdle, StHold} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [15:0] leds_q, leds_d;
    logic [1:0]  owner_q, owner_d;
    logic [3:0]  ack_q, ack_d;

    logic [1:0]  win;
    logic [1:0]  idx;
    logic        found;
    logic [15:0] win_val;

    // Rotating priority: first set req bit at or above ptr, wrapping 3->0.
    always_comb begin
        win   = ptr_q;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && bus.req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        win_val = bus.val0;
        unique case (win)
            2'd0: win_val = bus.val0;
            2'd1: win_val = bus.val1;
            2'd2: win_val = bus.val2;
            2'd3: win_val = bus.val3;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        leds_d  = leds_q;
        owner_d = owner_q;
        ack_d   = '0;
        case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StHold;
                    cnt_d   = 16'(HOLD_CYCLES - 1);
                    ptr_d   = win + 2'd1;
                    leds_d  = win_val;
                    owner_d = win;
                    ack_d   = 4'b0001 << win;
                end
            end
            StHold: begin
                // Requests are ignored here; they must still be high in IDLE to win.
                if (cnt_q == 16'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ptr_q   <= '0;
            leds_q  <= '0;
            owner_q <= '0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            leds_q  <= leds_d;
            owner_q <= owner_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.ack   = ack_q;
    assign bus.leds  = leds_q;
    assign bus.owner = owner_q;
    assign bus.busy  = (state_q == StHold);

endmodule

// File: tb/tb_leds_arbiter.sv
module tb_leds_arbiter;

    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

    leds_arbiter_if ba ();
    leds_arbiter_if bb ();

    leds_arbiter #(.HOLD_CYCLES(4)) u_dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (ba)
    );

    leds_arbiter #(.HOLD_CYCLES(1)) u_dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bb)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    logic [15:0] rr_leds [4];
    logic [3:0]  rr_ack  [4];

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rr_leds = '{16'h0002, 16'h0004, 16'h0008, 16'h0001};
        rr_ack  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

        reset   = 1'b0;
        ba.req  = '0; ba.val0 = '0; ba.val1 = '0; ba.val2 = '0; ba.val3 = '0;
        bb.req  = '0; bb.val0 = '0; bb.val1 = '0; bb.val2 = '0; bb.val3 = '0;
        #2;
        chk("rst_leds",  32'(ba.leds),  32'h0);
        chk("rst_ack",   32'(ba.ack),   32'h0);
        chk("rst_busy",  32'(ba.busy),  32'h0);
        chk("rst_owner", 32'(ba.owner), 32'h0);
        step(2);
        reset = 1'b1;
        step(1);
        chk("idle_busy", 32'(ba.busy), 32'h0);
        chk("idle_ack",  32'(ba.ack),  32'h0);

        // Single requester 2
        ba.req = 4'b0100; ba.val2 = 16'hA5A5;
        step(1);
        chk("single_leds",  32'(ba.leds),  32'hA5A5);
        chk("single_ack",   32'(ba.ack),   32'h4);
        chk("single_owner", 32'(ba.owner), 32'h2);
        chk("single_busy",  32'(ba.busy),  32'h1);
        ba.req = '0; ba.val2 = 16'h1234;
        step(1);
        chk("single_ack_1cyc", 32'(ba.ack),  32'h0);
        chk("single_busy_h2",  32'(ba.busy), 32'h1);
        step(2);
        chk("single_busy_h4",  32'(ba.busy), 32'h1);
        chk("single_val_late", 32'(ba.leds), 32'hA5A5);
        step(1);
        chk("single_busy_fall", 32'(ba.busy), 32'h0);
        chk("single_ack_idle",  32'(ba.ack),  32'h0);

        // Round robin from a fresh pointer
        #2; reset = 1'b0; #2; reset = 1'b1;
        ba.val0 = 16'h0001; ba.val1 = 16'h0002; ba.val2 = 16'h0004; ba.val3 = 16'h0008;
        ba.req  = 4'b1111;
        step(1);
        chk("rr_first_leds", 32'(ba.leds), 32'h0001);
        chk("rr_first_ack",  32'(ba.ack),  32'h1);
        for (int k = 0; k < 4; k++) begin
            step(4);
            chk("rr_hold_ack", 32'(ba.ack), 32'h0);
            step(1);
            chk("rr_leds", 32'(ba.leds), 32'(rr_leds[k]));
            chk("rr_ack",  32'(ba.ack),  32'(rr_ack[k]));
        end
        ba.req = '0;
        step(4);
        chk("rr_done_busy", 32'(ba.busy), 32'h0);

        // Pointer wrap: grant 3, then 0011 -> 0, then 1
        ba.req = 4'b1000;
        step(1);
        chk("wrap_owner3", 32'(ba.owner), 32'h3);
        chk("wrap_ack3",   32'(ba.ack),   32'h8);
        ba.req = 4'b0011;
        step(1);
        chk("wrap_hold_owner", 32'(ba.owner), 32'h3);
        step(3);
        chk("wrap_idle", 32'(ba.busy), 32'h0);
        step(1);
        chk("wrap_owner0", 32'(ba.owner), 32'h0);
        chk("wrap_ack0",   32'(ba.ack),   32'h1);
        step(4);
        step(1);
        chk("wrap_owner1", 32'(ba.owner), 32'h1);
        chk("wrap_ack1",   32'(ba.ack),   32'h2);
        ba.req = '0;
        step(4);

        // Requests and value changes ignored during HOLD
        ba.req = 4'b0001; ba.val0 = 16'h1111;
        step(1);
        chk("ign_grant", 32'(ba.leds), 32'h1111);
        ba.req = '0;
        step(1);
        ba.req = 4'b1000; ba.val0 = 16'h2222;
        step(1);
        chk("ign_leds",  32'(ba.leds),  32'h1111);
        chk("ign_owner", 32'(ba.owner), 32'h0);
        chk("ign_ack",   32'(ba.ack),   32'h0);
        step(1);
        ba.req = '0; ba.val0 = 16'h3333;
        step(2);
        chk("ign_no_grant_busy", 32'(ba.busy),  32'h0);
        chk("ign_no_grant_leds", 32'(ba.leds),  32'h1111);
        chk("ign_no_grant_own",  32'(ba.owner), 32'h0);
        chk("ign_no_grant_ack",  32'(ba.ack),   32'h0);

        // Reset in the second HOLD cycle
        ba.req = 4'b0001; ba.val0 = 16'hBEEF; ba.val1 = 16'h5A5A;
        step(1);
        chk("mid_leds_beef", 32'(ba.leds), 32'hBEEF);
        ba.req = '0;
        step(1);
        chk("mid_busy_h2", 32'(ba.busy), 32'h1);
        #2; reset = 1'b0; #1;
        chk("mid_rst_leds", 32'(ba.leds), 32'h0);
        chk("mid_rst_busy", 32'(ba.busy), 32'h0);
        chk("mid_rst_ack",  32'(ba.ack),  32'h0);
        ba.req = 4'b1010; reset = 1'b1;
        step(1);
        chk("post_rst_owner", 32'(ba.owner), 32'h1);
        chk("post_rst_ack",   32'(ba.ack),   32'h2);
        chk("post_rst_leds",  32'(ba.leds),  32'h5A5A);
        ba.req = '0;

        // HOLD_CYCLES=1 instance: grant every 2 cycles
        bb.req = 4'b0001; bb.val0 = 16'h00C3;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("h1_ack_on",  32'(bb.ack),  32'h1);
            chk("h1_busy_on", 32'(bb.busy), 32'h1);
            chk("h1_leds",    32'(bb.leds), 32'h00C3);
            step(1);
            chk("h1_ack_off",  32'(bb.ack),  32'h0);
            chk("h1_busy_off", 32'(bb.busy), 32'h0);
        end
        bb.req = '0;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/leds_arbiter.md
LEDS_ARBITER -- requirements
Module: leds_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 4, minimum cycles a granted value stays on leds before the next grant; legal range 1..65535.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req  input  4  per-requester write request; bit i belongs to requester i.
REQ-005 val0, val1, val2, val3  input  16 each  LED value offered by requester 0..3.
REQ-006 ack  output  4  one-cycle grant acknowledge; bit i belongs to requester i.
REQ-007 leds  output  16  registered LED drive value.
REQ-008 owner  output  2  index of the requester that last wrote leds.
REQ-009 busy  output  1  high while in HOLD.

Function
REQ-010 The block SHALL use a two-state FSM, IDLE and HOLD, plus a 16-bit hold counter cnt and a 2-bit round-robin pointer ptr.
REQ-011 In IDLE with req==0, the block SHALL stay in IDLE and leave leds, owner, ptr and ack (all zero) unchanged.
REQ-012 In IDLE with req!=0, the winner w SHALL be the first set bit of req, searched from index ptr upward with wrap 3->0.
REQ-013 A grant decided in cycle t SHALL produce the following at t+1: leds=val_w as sampled at t, owner=w, ack=one-hot(w), ptr=(w+1) mod 4, cnt=HOLD_CYCLES-1, state=HOLD.
REQ-014 ack SHALL be high for exactly the first HOLD cycle and zero in every other cycle; at most one ack bit SHALL be high at any time.
REQ-015 In HOLD, cnt SHALL decrement each cycle; when cnt==0, the next state SHALL be IDLE.
REQ-016 HOLD SHALL therefore last exactly HOLD_CYCLES cycles, and the minimum grant-to-grant spacing SHALL be HOLD_CYCLES+1 cycles.
REQ-017 Requests SHALL be ignored in HOLD: no arbitration and no change to leds, owner or ptr.
REQ-018 A requester SHALL keep req high until it sees its ack.
REQ-019 A req bit dropped before its ack SHALL be treated as withdrawn, with no grant and no error.
REQ-020 A req bit still high in the cycle after its ack SHALL be treated as a new request.
REQ-021 val_i SHALL be sampled only in the grant cycle; changes at any other time SHALL have no effect.
REQ-022 busy SHALL equal (state==HOLD).
REQ-023 All outputs SHALL be registered with no combinational path from inputs to outputs.
REQ-024 Fairness: with all four requesters continuously asserting, grants SHALL rotate 0,1,2,3,0,... with no requester starved.

Reset
REQ-025 While reset is low, the block SHALL force: state=IDLE, leds=16'h0000, owner=0, ack=0, busy=0, ptr=0, cnt=0.
REQ-026 Reset SHALL take effect asynchronously, including mid-HOLD.
REQ-027 Assertion of reset SHALL abort any pending ack without emitting it.
REQ-028 After reset deasserts, the first grant SHALL be decided on the first clock edge with req!=0, with ptr=0.

Verification (HOLD_CYCLES=4 unless stated)
REQ-029 Single requester: reset release, then req=4'b0100 and val2=16'hA5A5 at cycle t -> at t+1 leds=A5A5, ack=0100, owner=2, busy=1; busy falls at t+5; next grant possible at t+5, effective at t+6.
REQ-030 Round-robin: req=4'b1111 held, vals 0001/0002/0004/0008 -> leds sequence 0001,0002,0004,0008,0001, one change every 5 cycles, with matching one-hot ack each time.
REQ-031 Pointer wrap: after a grant to 3, req=4'b0011 -> grant 0; then after the HOLD, req=4'b0011 -> grant 1.
REQ-032 Ignore in HOLD: during HOLD, pulse req=4'b1000 for 2 cycles, then drop it, and toggle val0 -> leds, owner and ack remain unchanged, and no grant follows in IDLE.
REQ-033 Reset mid-HOLD: assert reset at the second HOLD cycle with leds=BEEF -> leds=0000, busy=0, ack=0 immediately; the first post-reset grant with req=4'b1010 goes to 1.
REQ-034 HOLD_CYCLES=1: req=4'b0001 held -> grants every 2 cycles, ack pulse of width 1, busy high 1 cycle per grant.
